// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a power-of-two FIFO feeding a start/data/parity/stop frame engine.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits (PARITY_ODD selects odd).
module uart_tx_fifo #(
  parameter int CLOCK_FREQ = 33_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        data_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic                        serial_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(SYMBOL_EDGE_TIME * 2);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [TMR_W-1:0] BIT_LAST   = TMR_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [TMR_W-1:0] STOP_LAST  = TMR_W'(STOP_BITS * SYMBOL_EDGE_TIME - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  state_t               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 serial_q, serial_d;
  logic                 busy_q, busy_d;

  logic                 push;
  logic                 pop;
  logic                 bit_done;
  logic [DATA_BITS-1:0] head;

  // Ready depends only on occupancy, so a full FIFO refuses data even when a pop is under way.
  assign data_in_ready = (count_q != FULL_COUNT);
  assign push          = data_in_valid && data_in_ready && !reset;
  assign head          = mem_q[rd_ptr_q];
  assign bit_done      = (timer_q == BIT_LAST);

  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_d = '0;
          if (bit_idx_q == DATA_LAST) begin
            state_d = AFTER_DATA;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_done) begin
          timer_d = '0;
          state_d = STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        // The stop symbol spans all stop bits with one count, then chains straight into the next frame.
        if (timer_q == STOP_LAST) begin
          timer_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    if (pop) begin
      shift_d  = head;
      parity_d = (^head) ^ PARITY_ODD[0];
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Line level follows the state one cycle later, so every symbol keeps its full width.
  always_comb begin
    case (state_q)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_q[0];
      PARITY:  serial_d = parity_q;
      default: serial_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE) || (count_q != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: two configurations (8N1 even, 5-bit/2-stop odd) share one stimulus
// stream and are compared every cycle against a queue-and-timeline reference model.
module tb_uart_tx_fifo;

   localparam int SET        = 10;
   localparam int FIFO_DEPTH = 4;
   localparam int MAXC       = 8000;
   localparam int NEVER      = -100000;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       data_in_valid = 1'b0;
   logic [7:0] data_in = 8'h00;

   logic       ready0, ser0, busy0;
   logic [2:0] cnt0;
   logic       ready1, ser1, busy1;
   logic [2:0] cnt1;

   int         tests_run = 0;
   int         tests_failed = 0;
   int         cyc = 0;
   int         last_pop [2];
   logic [7:0] mq [2][$];
   bit         exp_line [2][MAXC];
   logic       acc;
   logic       acc_dummy;
   int         attempts;
   int         guard;

   // Free-running clock; outputs are sampled 1 time unit after each rising edge.
   always #5 clk = ~clk;

   uart_tx_fifo #(
      .CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1),
      .FIFO_DEPTH(FIFO_DEPTH), .PARITY_ODD(0)
   ) u_dut8 (
      .clk(clk), .reset(reset), .data_in(data_in), .data_in_valid(data_in_valid),
      .data_in_ready(ready0), .serial_out(ser0), .busy(busy0), .fifo_count(cnt0)
   );

   uart_tx_fifo #(
      .CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(5), .STOP_BITS(2),
      .FIFO_DEPTH(FIFO_DEPTH), .PARITY_ODD(1)
   ) u_dut5 (
      .clk(clk), .reset(reset), .data_in(data_in[4:0]), .data_in_valid(data_in_valid),
      .data_in_ready(ready1), .serial_out(ser1), .busy(busy1), .fifo_count(cnt1)
   );

   // Configuration of each modelled instance.
   function automatic int dataBits(input int i);
      return (i == 0) ? 8 : 5;
   endfunction

   function automatic int stopBits(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   function automatic logic oddParity(input int i);
      return (i == 0) ? 1'b0 : 1'b1;
   endfunction

   function automatic int frameLen(input int i);
      return (1 + dataBits(i) + PAR + stopBits(i)) * SET;
   endfunction

   // Line level of symbol s in the frame carrying byte b.
   function automatic bit frameBit(input int i, input logic [7:0] b, input int s);
      if (s == 0) return 1'b0;
      if (s <= dataBits(i)) return b[s-1];
      if (PAR == 1 && s == dataBits(i) + 1) return (^b) ^ oddParity(i);
      return 1'b1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, observed, expected);
         $error("[TB] %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, advances the reference model across the edge and checks both instances.
   task automatic applyStimulus(input logic rst, input logic vld, input logic [7:0] d, output logic accepted);
      int         pre;
      logic [7:0] b;
      logic       exp_busy [2];
      logic       pushed [2];
      reset         = rst;
      data_in_valid = vld;
      data_in       = d;
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
         pre       = mq[i].size();
         pushed[i] = 1'b0;
         if (rst) begin
            mq[i].delete();
            last_pop[i] = NEVER;
            exp_busy[i] = 1'b0;
            for (int j = cyc; j < MAXC; j++) exp_line[i][j] = 1'b1;
         end else begin
            exp_busy[i] = (pre != 0) || (cyc > last_pop[i] && cyc <= last_pop[i] + frameLen(i));
            if (pre != 0 && cyc >= last_pop[i] + frameLen(i)) begin
               b = mq[i].pop_front();
               last_pop[i] = cyc;
               for (int s = 0; s < frameLen(i); s++)
                  if (cyc + 1 + s < MAXC) exp_line[i][cyc + 1 + s] = frameBit(i, b, s / SET);
            end
            pushed[i] = vld && (pre < FIFO_DEPTH);
            if (pushed[i]) mq[i].push_back((i == 0) ? d : (d & 8'h1F));
         end
      end
      #1;
      checkOutput("count8", cnt0,   mq[0].size());
      checkOutput("ready8", ready0, mq[0].size() < FIFO_DEPTH);
      checkOutput("busy8",  busy0,  exp_busy[0]);
      checkOutput("line8",  ser0,   exp_line[0][cyc]);
      checkOutput("count5", cnt1,   mq[1].size());
      checkOutput("ready5", ready1, mq[1].size() < FIFO_DEPTH);
      checkOutput("busy5",  busy1,  exp_busy[1]);
      checkOutput("line5",  ser1,   exp_line[1][cyc]);
      accepted = pushed[0];
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) applyStimulus(1'b0, 1'b0, 8'h00, acc_dummy);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         last_pop[i] = NEVER;
         for (int j = 0; j < MAXC; j++) exp_line[i][j] = 1'b1;
      end

      // Reset, including a push attempted while reset is high.
      repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, acc);
      applyStimulus(1'b1, 1'b1, 8'h3C, acc);
      idle(4);

      // Single frame from an idle engine.
      applyStimulus(1'b0, 1'b1, 8'hA5, acc);
      idle(120);

      // Burst behind a frame already in flight: four fill the FIFO, the fifth waits for a pop.
      applyStimulus(1'b0, 1'b1, 8'hFF, acc);
      for (int v = 1; v <= 5; v++) begin
         acc = 1'b0;
         attempts = 0;
         while (!acc && attempts < 300) begin
            applyStimulus(1'b0, 1'b1, 8'(v), acc);
            attempts++;
         end
         checkOutput("burst_accept", acc, 1);
         if (v == 4) checkOutput("ready_full", ready0, 0);
         if (v == 5) checkOutput("burst5_held", attempts > 50, 1);
      end
      idle(620);

      // Push landing on the same edge as a pop while two entries are queued.
      applyStimulus(1'b0, 1'b1, 8'h11, acc);
      applyStimulus(1'b0, 1'b1, 8'h22, acc);
      applyStimulus(1'b0, 1'b1, 8'h33, acc);
      guard = 0;
      while (cyc + 1 < last_pop[0] + frameLen(0) && guard < 300) begin
         idle(1);
         guard++;
      end
      checkOutput("pop_wait", guard < 300, 1);
      applyStimulus(1'b0, 1'b1, 8'h44, acc);
      checkOutput("count_push_pop", cnt0, 2);
      idle(420);

      // Reset during data bit 3 with two entries queued behind the frame.
      applyStimulus(1'b0, 1'b1, 8'h5A, acc);
      applyStimulus(1'b0, 1'b1, 8'h6B, acc);
      applyStimulus(1'b0, 1'b1, 8'h7C, acc);
      guard = 0;
      while (cyc < last_pop[0] + 1 + 4 * SET + 3 && guard < 300) begin
         idle(1);
         guard++;
      end
      applyStimulus(1'b1, 1'b0, 8'h00, acc);
      checkOutput("abort_line", ser0, 1);
      checkOutput("abort_count", cnt0, 0);
      checkOutput("abort_ready", ready0, 1);
      idle(150);

      // Random traffic with occasional resets, then drain.
      for (int k = 0; k < 400; k++)
         applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, 8'($urandom), acc);
      idle(600);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
